// File: rtl/counter_pad_ctrl.sv
// counter_pad_ctrl: owns the shared bidirectional pad bus between the counter
// core and the tester. It synchronises the oeb/web pad strobes, arbitrates
// between readout (chip drives) and preload (tester drives) with a forced
// turnaround gap, and turns a completed write window into one load strobe.
module counter_pad_ctrl #(
    parameter int WIDTH       = 41,
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             oeb_in,
    input  logic             web_in,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic             pad_oe,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_en,
    output logic             conflict
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DRIVE     = 3'd1;
    localparam logic [2:0] S_TURN      = 3'd2;
    localparam logic [2:0] S_LOAD_WAIT = 3'd3;
    localparam logic [2:0] S_LOAD      = 3'd4;

    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_oeb_sync;
    logic [SYNC_STAGES-1:0] r_web_sync;
    logic [WIDTH-1:0]       r_pad_sync [SYNC_STAGES];

    logic                   w_oeb_s;
    logic                   w_web_s;
    logic [WIDTH-1:0]       w_pad_s;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [TW-1:0]          r_turn_cnt;
    logic [TW-1:0]          w_turn_nxt;
    logic                   w_conflict_nxt;

    logic [WIDTH-1:0]       r_pad_out;
    logic                   r_pad_oe;
    logic                   r_cnt_load;
    logic [WIDTH-1:0]       r_cnt_load_val;
    logic                   r_cnt_en;
    logic                   r_conflict;

    // Equal-depth synchronisers so strobes and data stay aligned in time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oeb_sync <= '1;
            r_web_sync <= '1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_pad_sync[i] <= '0;
            end
        end else begin
            r_oeb_sync    <= {r_oeb_sync[SYNC_STAGES-2:0], oeb_in};
            r_web_sync    <= {r_web_sync[SYNC_STAGES-2:0], web_in};
            r_pad_sync[0] <= pad_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_pad_sync[i] <= r_pad_sync[i-1];
            end
        end
    end

    assign w_oeb_s = r_oeb_sync[SYNC_STAGES-1];
    assign w_web_s = r_web_sync[SYNC_STAGES-1];
    assign w_pad_s = r_pad_sync[SYNC_STAGES-1];

    // Next-state logic; a web request seen in DRIVE first spends one DRIVE
    // cycle flagging the conflict, then always goes through TURN so the pad
    // drivers are off before the tester can be granted the bus.
    always_comb begin
        w_state_nxt    = r_state;
        w_turn_nxt     = r_turn_cnt;
        w_conflict_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_web_s) begin
                    w_state_nxt = S_LOAD_WAIT;
                end else if (!w_oeb_s) begin
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_conflict) begin
                    w_state_nxt = S_TURN;
                    w_turn_nxt  = TW'(TURN_CYCLES - 1);
                end else if (!w_web_s) begin
                    w_conflict_nxt = 1'b1;
                end else if (w_oeb_s) begin
                    w_state_nxt = S_TURN;
                    w_turn_nxt  = TW'(TURN_CYCLES - 1);
                end
            end
            S_TURN: begin
                if (r_turn_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_turn_nxt = r_turn_cnt - 1'b1;
                end
            end
            S_LOAD_WAIT: begin
                if (w_web_s) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State plus registered outputs, all decoded from the next state so each
    // output is valid in the same cycle as the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_turn_cnt     <= '0;
            r_pad_out      <= '0;
            r_pad_oe       <= 1'b0;
            r_cnt_load     <= 1'b0;
            r_cnt_load_val <= '0;
            r_cnt_en       <= 1'b0;
            r_conflict     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_turn_cnt <= w_turn_nxt;
            r_pad_oe   <= (w_state_nxt == S_DRIVE);
            r_cnt_en   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DRIVE) ||
                          (w_state_nxt == S_TURN);
            r_cnt_load <= (w_state_nxt == S_LOAD);
            r_conflict <= w_conflict_nxt;
            if (w_state_nxt == S_DRIVE) begin
                r_pad_out <= cnt_q;
            end
            if ((w_state_nxt == S_LOAD_WAIT) && !w_web_s) begin
                r_cnt_load_val <= w_pad_s;
            end
        end
    end

    assign pad_out      = r_pad_out;
    assign pad_oe       = r_pad_oe;
    assign cnt_load     = r_cnt_load;
    assign cnt_load_val = r_cnt_load_val;
    assign cnt_en       = r_cnt_en;
    assign conflict     = r_conflict;

endmodule

// File: tb/tb_counter_pad_ctrl.sv
// Bench for counter_pad_ctrl: a transaction-level model (delay-line view of
// the synchronised pads plus a mode tracker) checked against the DUT on every
// falling edge, plus directed scenarios with literal expectations.
module tb_counter_pad_ctrl;

    localparam int W  = 41;
    localparam int S  = 2;
    localparam int TC = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         oeb_in = 1'b0;
    logic         web_in = 1'b0;
    logic [W-1:0] pad_in = '0;
    logic [W-1:0] cnt_q = 41'h100;
    logic [W-1:0] pad_out;
    logic         pad_oe;
    logic         cnt_load;
    logic [W-1:0] cnt_load_val;
    logic         cnt_en;
    logic         conflict;

    int tests = 0;
    int failed = 0;
    int n_conf = 0;
    int n_load = 0;
    int n_oe = 0;

    counter_pad_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .TURN_CYCLES(TC)) dut (
        .clk(clk), .rst_n(rst_n), .oeb_in(oeb_in), .web_in(web_in),
        .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .cnt_q(cnt_q),
        .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    // free-running counter value, changed away from both clock edges
    initial forever begin
        @(posedge clk);
        #2 cnt_q = cnt_q + 41'd1;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_DRIVE, M_TURN, M_LWAIT, M_LOAD} mode_t;
    mode_t        m_mode = M_IDLE;
    int           m_turn_left = 0;
    bit           m_oe = 0, m_en = 0, m_ld = 0, m_cf = 0, cf_now = 0;
    logic [W-1:0] m_out = '0, m_val = '0;
    bit           q_oeb[$];
    bit           q_web[$];
    logic [W-1:0] q_pad[$];
    bit           so, sw;
    logic [W-1:0] sp;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q_oeb = {}; q_web = {}; q_pad = {};
            repeat (S) begin
                q_oeb.push_back(1'b1); q_web.push_back(1'b1); q_pad.push_back('0);
            end
            m_mode = M_IDLE; m_turn_left = 0;
            m_oe = 0; m_en = 0; m_ld = 0; m_cf = 0; m_out = '0; m_val = '0;
        end else begin
            // what the core sees now is the pad state from S edges ago
            so = q_oeb.pop_front(); sw = q_web.pop_front(); sp = q_pad.pop_front();
            q_oeb.push_back(oeb_in); q_web.push_back(web_in); q_pad.push_back(pad_in);
            cf_now = 0;
            case (m_mode)
                M_IDLE:
                    if (!sw) begin m_mode = M_LWAIT; m_val = sp; end
                    else if (!so) begin m_mode = M_DRIVE; m_out = cnt_q; end
                M_DRIVE:
                    if (m_cf) begin m_mode = M_TURN; m_turn_left = TC; end
                    else if (!sw) begin cf_now = 1; m_out = cnt_q; end
                    else if (so) begin m_mode = M_TURN; m_turn_left = TC; end
                    else m_out = cnt_q;
                M_TURN: begin
                    m_turn_left--;
                    if (m_turn_left == 0) m_mode = M_IDLE;
                end
                M_LWAIT:
                    if (sw) m_mode = M_LOAD;
                    else m_val = sp;
                default: m_mode = M_IDLE;
            endcase
            m_cf = cf_now;
            m_oe = (m_mode == M_DRIVE);
            m_en = (m_mode != M_LWAIT) && (m_mode != M_LOAD);
            m_ld = (m_mode == M_LOAD);
        end
    end

    // per-cycle comparison against the model, plus event counters
    initial forever begin
        @(negedge clk);
        check("pad_oe",       {40'd0, pad_oe},   {40'd0, m_oe});
        check("cnt_en",       {40'd0, cnt_en},   {40'd0, m_en});
        check("cnt_load",     {40'd0, cnt_load}, {40'd0, m_ld});
        check("conflict",     {40'd0, conflict}, {40'd0, m_cf});
        check("pad_out",      pad_out,      m_out);
        check("cnt_load_val", cnt_load_val, m_val);
        if (conflict) n_conf++;
        if (cnt_load) n_load++;
        if (pad_oe) n_oe++;
    end

    task automatic wait_load(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (cnt_load) found = 1;
        end
        tests++;
        if (!found) begin
            failed++;
            $display("FAIL %s: got no cnt_load expected one within 12 cycles", name);
        end
    endtask

    int c0, l0, p0;

    initial begin
        // reset with both strobes low
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_pad_oe",   {40'd0, pad_oe},   41'd0);
        check("rst_cnt_en",   {40'd0, cnt_en},   41'd0);
        check("rst_cnt_load", {40'd0, cnt_load}, 41'd0);
        #2 rst_n = 1'b1;
        tick(2);
        check("rst_idle_en", {40'd0, cnt_en}, 41'd1);
        tick(1);
        check("rst_lwait_en", {40'd0, cnt_en}, 41'd0);
        web_in = 1'b1; oeb_in = 1'b1;
        tick(6);

        // readout
        oeb_in = 1'b0;
        tick(2);
        check("rd_oe_early", {40'd0, pad_oe}, 41'd0);
        tick(1);
        check("rd_oe_rise", {40'd0, pad_oe}, 41'd1);
        check("rd_lag", pad_out, cnt_q - 41'd1);
        tick(7);
        check("rd_lag2", pad_out, cnt_q - 41'd1);
        oeb_in = 1'b1;
        tick(2);
        check("rd_oe_hold", {40'd0, pad_oe}, 41'd1);
        tick(1);
        check("rd_oe_fall", {40'd0, pad_oe}, 41'd0);
        tick(1);
        check("rd_idle_oe", {40'd0, pad_oe}, 41'd0);
        check("rd_idle_en", {40'd0, cnt_en}, 41'd1);

        // load
        web_in = 1'b0; pad_in = 41'h123456789A;
        tick(6);
        check("ld_win_en", {40'd0, cnt_en}, 41'd0);
        web_in = 1'b1; pad_in = '0;
        wait_load("ld_strobe");
        check("ld_val", cnt_load_val, 41'h123456789A);
        tick(1);
        check("ld_after_en", {40'd0, cnt_en}, 41'd1);
        check("ld_after_ld", {40'd0, cnt_load}, 41'd0);
        tick(2);

        // conflict
        c0 = n_conf;
        oeb_in = 1'b0;
        tick(5);
        web_in = 1'b0; pad_in = 41'h55;
        tick(8);
        web_in = 1'b1; oeb_in = 1'b1; pad_in = '0;
        wait_load("cf_strobe");
        check("cf_val", cnt_load_val, 41'h55);
        tick(3);
        check("cf_pulses", 41'(n_conf - c0), 41'd1);

        // simultaneous request
        p0 = n_oe; l0 = n_load;
        oeb_in = 1'b0; web_in = 1'b0; pad_in = 41'h1F0F0;
        tick(5);
        oeb_in = 1'b1; web_in = 1'b1; pad_in = '0;
        wait_load("sim_strobe");
        check("sim_val", cnt_load_val, 41'h1F0F0);
        tick(3);
        check("sim_no_oe", 41'(n_oe - p0), 41'd0);
        check("sim_one_ld", 41'(n_load - l0), 41'd1);

        // reset during a load window
        web_in = 1'b0; pad_in = 41'hABC;
        tick(5);
        check("rml_lwait_en", {40'd0, cnt_en}, 41'd0);
        l0 = n_load;
        #2 rst_n = 1'b0;
        web_in = 1'b1; pad_in = '0;
        tick(1);
        check("rml_val_rst", cnt_load_val, 41'd0);
        #2 rst_n = 1'b1;
        tick(10);
        check("rml_no_ld", 41'(n_load - l0), 41'd0);
        check("rml_val", cnt_load_val, 41'd0);
        check("rml_idle_en", {40'd0, cnt_en}, 41'd1);
        check("rml_idle_oe", {40'd0, pad_oe}, 41'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
